// File: rtl/ysyx_25040129_axil_xbar_pkg.sv
// rtl/ysyx_25040129_axil_xbar_pkg.sv - shared resp codes, FSM states and default SoC address map
package ysyx_25040129_axil_xbar_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        R_IDLE, R_REQ, R_DATA, R_ERR, R_ERESP
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
        , R_DRAIN
`endif
    } r_state_e;

    typedef enum logic [2:0] {
        W_IDLE, W_REQ, W_RESP, W_ERR, W_ERESP
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
        , W_DRAIN
`endif
    } w_state_e;

    localparam logic [31:0] MAP_ROM_BASE   = 32'h2000_0000, MAP_ROM_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] MAP_SRAM_BASE  = 32'h0F00_0000, MAP_SRAM_MASK  = 32'hFFFF_E000;
    localparam logic [31:0] MAP_UART_BASE  = 32'h1000_0000, MAP_UART_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] MAP_SPI_BASE   = 32'h1000_1000, MAP_SPI_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] MAP_GPIO_BASE  = 32'h1000_2000, MAP_GPIO_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] MAP_PS2_BASE   = 32'h1001_1000, MAP_PS2_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] MAP_FLASH_BASE = 32'h3000_0000, MAP_FLASH_MASK = 32'hF000_0000;
    localparam logic [31:0] MAP_PSRAM_BASE = 32'h8000_0000, MAP_PSRAM_MASK = 32'hE000_0000;
    localparam logic [31:0] MAP_SDRAM_BASE = 32'hA000_0000, MAP_SDRAM_MASK = 32'hE000_0000;
    localparam logic [31:0] MAP_RTC_BASE   = 32'h0200_0000, MAP_RTC_MASK   = 32'hFFFF_0000;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_25040129_axil_xbar_if.sv
// rtl/ysyx_25040129_axil_xbar_if.sv - AXI4-Lite bus bundle, N lanes flattened per field
interface ysyx_25040129_axil_xbar_if #(
    parameter int N  = 1,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [N*AW-1:0]     araddr;
    logic [N-1:0]        arvalid;
    logic [N*3-1:0]      arsize;
    logic [N-1:0]        arready;
    logic [N*DW-1:0]     rdata;
    logic [N*2-1:0]      rresp;
    logic [N-1:0]        rvalid;
    logic [N-1:0]        rready;
    logic [N*AW-1:0]     awaddr;
    logic [N-1:0]        awvalid;
    logic [N-1:0]        awready;
    logic [N*DW-1:0]     wdata;
    logic [N*DW/8-1:0]   wstrb;
    logic [N-1:0]        wvalid;
    logic [N-1:0]        wready;
    logic [N*2-1:0]      bresp;
    logic [N-1:0]        bvalid;
    logic [N-1:0]        bready;

    modport master (
        output araddr, arvalid, arsize, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, arsize, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_25040129_xbar_decode.sv
// rtl/ysyx_25040129_xbar_decode.sv - base/mask address decoder, lowest matching index wins
module ysyx_25040129_xbar_decode
    import ysyx_25040129_axil_xbar_pkg::*;
#(
    parameter int                   NSLV     = 4,
    parameter int                   AW       = 32,
    parameter logic [NSLV*AW-1:0]   SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0]   SLV_MASK = '0,
    localparam int                  IW       = idx_width(NSLV)
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    // Scan downward so the lowest matching slave is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ysyx_25040129_axil_xbar.sv
// rtl/ysyx_25040129_axil_xbar.sv - AXI4-Lite 1-to-NSLV crossbar with internal error responses
// Optional response watchdog and drain: YSYX_25040129_XBAR_TIMEOUT_EN
module ysyx_25040129_axil_xbar
    import ysyx_25040129_axil_xbar_pkg::*;
#(
    parameter int                   NSLV        = 4,
    parameter int                   AW          = 32,
    parameter int                   DW          = 32,
    parameter logic [NSLV*AW-1:0]   SLV_BASE    = '0,
    parameter logic [NSLV*AW-1:0]   SLV_MASK    = '0,
    parameter logic [NSLV-1:0]      SLV_WR      = '1,
    parameter int                   TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_25040129_axil_xbar_if.slave    m,
    ysyx_25040129_axil_xbar_if.master   s
);

    localparam int IW = idx_width(NSLV);

    if (NSLV < 1 || NSLV > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("ysyx_25040129_axil_xbar: NSLV must be 1..8 and TIMEOUT_CYC at least 2");
    end

    logic          ar_hit, aw_hit;
    logic [IW-1:0] ar_idx, aw_idx;

    ysyx_25040129_xbar_decode #(.NSLV(NSLV), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
        u_ar_dec (.addr(m.araddr), .hit(ar_hit), .idx(ar_idx));
    ysyx_25040129_xbar_decode #(.NSLV(NSLV), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
        u_aw_dec (.addr(m.awaddr), .hit(aw_hit), .idx(aw_idx));

    r_state_e      r_state;
    logic [IW-1:0] r_sel;
    logic [AW-1:0] r_addr;
    logic [2:0]    r_size;
    logic [1:0]    r_eresp;

    w_state_e      w_state;
    logic [IW-1:0] w_sel;
    logic [AW-1:0] w_addr;
    logic [1:0]    w_eresp;
    logic          aw_done, w_done;

`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_cnt, w_cnt;
    logic          r_to, w_to;
`endif

    logic s_ar_hs, m_r_hs, s_aw_hs, s_w_hs, m_b_hs;
    assign s_ar_hs = (r_state == R_REQ) && s.arready[r_sel];
    assign m_r_hs  = m.rvalid && m.rready;
    assign s_aw_hs = (w_state == W_REQ) && !aw_done && s.awready[w_sel];
    assign s_w_hs  = (w_state == W_REQ) && !w_done && s.wready[w_sel];
    assign m_b_hs  = m.bvalid && m.bready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_sel   <= '0;
            r_addr  <= '0;
            r_size  <= '0;
            r_eresp <= RESP_OKAY;
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
            r_cnt   <= '0;
            r_to    <= 1'b0;
`endif
        end else begin
            case (r_state)
                R_IDLE: if (m.arvalid) begin
                    r_sel   <= ar_idx;
                    r_addr  <= m.araddr;
                    r_size  <= m.arsize;
                    r_eresp <= RESP_DECERR;
                    r_state <= ar_hit ? R_REQ : R_ERR;
                end
                R_REQ: if (s_ar_hs) begin
                    r_state <= R_DATA;
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                R_DATA: begin
                    if (m_r_hs) r_state <= R_IDLE;
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
                    else if (!s.rvalid[r_sel]) begin
                        if (r_cnt == TW'(TIMEOUT_CYC - 1)) begin
                            r_eresp <= RESP_SLVERR;
                            r_to    <= 1'b1;
                            r_state <= R_ERESP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`endif
                end
                R_ERR:   r_state <= R_ERESP;
                R_ERESP: if (m.rready) begin
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
                    r_state <= r_to ? R_DRAIN : R_IDLE;
                    r_to    <= 1'b0;
`else
                    r_state <= R_IDLE;
`endif
                end
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
                R_DRAIN: if (s.rvalid[r_sel]) r_state <= R_IDLE;
`endif
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            w_sel   <= '0;
            w_addr  <= '0;
            w_eresp <= RESP_OKAY;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
            w_cnt   <= '0;
            w_to    <= 1'b0;
`endif
        end else begin
            case (w_state)
                W_IDLE: if (m.awvalid && m.wvalid) begin
                    w_sel   <= aw_idx;
                    w_addr  <= m.awaddr;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    w_eresp <= aw_hit ? RESP_SLVERR : RESP_DECERR;
                    w_state <= (aw_hit && SLV_WR[aw_idx]) ? W_REQ : W_ERR;
                end
                // aw and w complete independently; both may land on the same edge.
                W_REQ: begin
                    if ((aw_done || s_aw_hs) && (w_done || s_w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        w_state <= W_RESP;
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
                        w_cnt   <= '0;
`endif
                    end else begin
                        if (s_aw_hs) aw_done <= 1'b1;
                        if (s_w_hs)  w_done  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (m_b_hs) w_state <= W_IDLE;
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
                    else if (!s.bvalid[w_sel]) begin
                        if (w_cnt == TW'(TIMEOUT_CYC - 1)) begin
                            w_eresp <= RESP_SLVERR;
                            w_to    <= 1'b1;
                            w_state <= W_ERESP;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
`endif
                end
                W_ERR:   w_state <= W_ERESP;
                W_ERESP: if (m.bready) begin
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
                    w_state <= w_to ? W_DRAIN : W_IDLE;
                    w_to    <= 1'b0;
`else
                    w_state <= W_IDLE;
`endif
                end
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
                W_DRAIN: if (s.bvalid[w_sel]) w_state <= W_IDLE;
`endif
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        m.arready = 1'b0;
        m.rvalid  = 1'b0;
        m.rdata   = '0;
        m.rresp   = '0;
        s.arvalid = '0;
        s.araddr  = '0;
        s.arsize  = '0;
        s.rready  = '0;
        case (r_state)
            R_REQ: begin
                s.arvalid[r_sel]               = 1'b1;
                s.araddr[int'(r_sel)*AW +: AW] = r_addr;
                s.arsize[int'(r_sel)*3 +: 3]   = r_size;
                m.arready                      = s.arready[r_sel];
            end
            R_DATA: begin
                m.rvalid        = s.rvalid[r_sel];
                m.rdata         = s.rdata[int'(r_sel)*DW +: DW];
                m.rresp         = s.rresp[int'(r_sel)*2 +: 2];
                s.rready[r_sel] = m.rready;
            end
            R_ERR:   m.arready = 1'b1;
            R_ERESP: begin
                m.rvalid = 1'b1;
                m.rresp  = r_eresp;
            end
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
            R_DRAIN: s.rready[r_sel] = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        m.awready = 1'b0;
        m.wready  = 1'b0;
        m.bvalid  = 1'b0;
        m.bresp   = '0;
        s.awvalid = '0;
        s.awaddr  = '0;
        s.wvalid  = '0;
        s.wdata   = '0;
        s.wstrb   = '0;
        s.bready  = '0;
        case (w_state)
            W_REQ: begin
                s.awvalid[w_sel]                       = !aw_done;
                s.awaddr[int'(w_sel)*AW +: AW]         = w_addr;
                m.awready                              = !aw_done && s.awready[w_sel];
                s.wvalid[w_sel]                        = !w_done;
                s.wdata[int'(w_sel)*DW +: DW]          = m.wdata;
                s.wstrb[int'(w_sel)*(DW/8) +: (DW/8)]  = m.wstrb;
                m.wready                               = !w_done && s.wready[w_sel];
            end
            W_RESP: begin
                m.bvalid        = s.bvalid[w_sel];
                m.bresp         = s.bresp[int'(w_sel)*2 +: 2];
                s.bready[w_sel] = m.bready;
            end
            W_ERR: begin
                m.awready = 1'b1;
                m.wready  = 1'b1;
            end
            W_ERESP: begin
                m.bvalid = 1'b1;
                m.bresp  = w_eresp;
            end
`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
            W_DRAIN: s.bready[w_sel] = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_axil_xbar.sv
// tb/tb_ysyx_25040129_axil_xbar.sv - directed bench for the AXI4-Lite crossbar, two slaves
module tb_ysyx_25040129_axil_xbar;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_25040129_axil_xbar_if #(.N(1), .AW(32), .DW(32)) mi ();
    ysyx_25040129_axil_xbar_if #(.N(2), .AW(32), .DW(32)) si ();

    ysyx_25040129_axil_xbar #(
        .NSLV(2), .AW(32), .DW(32),
        .SLV_BASE({32'h0200_0000, 32'h2000_0000}),
        .SLV_MASK({32'hFFFF_0000, 32'hF000_0000}),
        .SLV_WR(2'b10),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .m(mi), .s(si)
    );

    int n_vec = 0;
    int n_err = 0;
    int aw_hs1 = 0;
    int w_hs1  = 0;

    always @(posedge clk) begin
        if (si.awvalid[1] && si.awready[1]) aw_hs1++;
        if (si.wvalid[1] && si.wready[1]) w_hs1++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int aw0, w0, cyc;

    initial begin
        mi.araddr = '0; mi.arvalid = 0; mi.arsize = '0; mi.rready = 0;
        mi.awaddr = '0; mi.awvalid = 0; mi.wdata = '0; mi.wstrb = '0; mi.wvalid = 0; mi.bready = 0;
        si.arready = '0; si.rdata = '0; si.rresp = '0; si.rvalid = '0;
        si.awready = '0; si.wready = '0; si.bresp = '0; si.bvalid = '0;

        // reset state
        repeat (2) tick();
        chk("rst_arready", mi.arready, 0);
        chk("rst_rvalid", mi.rvalid, 0);
        chk("rst_rdata", mi.rdata, 0);
        chk("rst_awready", mi.awready, 0);
        chk("rst_wready", mi.wready, 0);
        chk("rst_bvalid", mi.bvalid, 0);
        chk("rst_s_valids", {si.arvalid, si.awvalid, si.wvalid, si.rready, si.bready}, 0);
        rst = 1'b1;
        tick();

        // mapped read of slave1
        mi.araddr = 32'h0200_0048; mi.arsize = 3'd2; mi.arvalid = 1; mi.rready = 1;
        #1;
        chk("rd_arvalid_c0", si.arvalid, 2'b00);
        chk("rd_arready_c0", mi.arready, 0);
        tick();
        chk("rd_arvalid_c1", si.arvalid, 2'b10);
        chk("rd_araddr", si.araddr[63:32], 32'h0200_0048);
        chk("rd_arsize", si.arsize[5:3], 3'd2);
        si.arready = 2'b10;
        #1;
        chk("rd_arready_hs", mi.arready, 1);
        tick();
        mi.arvalid = 0; si.arready = 0;
        si.rvalid = 2'b10; si.rdata = {32'hCAFE_F00D, 32'h1111_1111}; si.rresp = 4'b0000;
        #1;
        chk("rd_rvalid", mi.rvalid, 1);
        chk("rd_rdata", mi.rdata, 32'hCAFE_F00D);
        chk("rd_rresp", mi.rresp, 2'b00);
        chk("rd_s_rready", si.rready, 2'b10);
        tick();
        si.rvalid = 0;
        #1;
        chk("rd_done_rvalid", mi.rvalid, 0);

        // unmapped read
        mi.araddr = 32'hDEAD_0000; mi.arvalid = 1; mi.rready = 0;
        tick();
        chk("err_rd_arready_c1", mi.arready, 1);
        chk("err_rd_no_s_arvalid", si.arvalid, 0);
        tick();
        mi.arvalid = 0;
        #1;
        chk("err_rd_rvalid_c2", mi.rvalid, 1);
        chk("err_rd_rdata", mi.rdata, 0);
        chk("err_rd_rresp", mi.rresp, 2'b11);
        tick();
        chk("err_rd_rvalid_held", mi.rvalid, 1);
        chk("err_rd_no_s_arvalid2", si.arvalid, 0);
        mi.rready = 1;
        tick();
        chk("err_rd_done", mi.rvalid, 0);

        // write to read-only slave0
        si.awready = 2'b11; si.wready = 2'b11;
        mi.awaddr = 32'h2000_0010; mi.wdata = 32'h5555_AAAA; mi.wstrb = 4'hF;
        mi.awvalid = 1; mi.wvalid = 1; mi.bready = 1;
        tick();
        chk("ro_wr_awready", mi.awready, 1);
        chk("ro_wr_wready", mi.wready, 1);
        chk("ro_wr_no_s_aw_w", {si.awvalid, si.wvalid}, 0);
        tick();
        mi.awvalid = 0; mi.wvalid = 0;
        #1;
        chk("ro_wr_bvalid", mi.bvalid, 1);
        chk("ro_wr_bresp", mi.bresp, 2'b10);
        chk("ro_wr_no_s_aw_w2", {si.awvalid, si.wvalid}, 0);
        tick();
        chk("ro_wr_done", mi.bvalid, 0);
        si.awready = 0; si.wready = 0;

        // slave1 takes w three cycles before aw
        aw0 = aw_hs1; w0 = w_hs1;
        mi.awaddr = 32'h0200_0100; mi.wdata = 32'h0123_4567; mi.wstrb = 4'h3;
        mi.awvalid = 1; mi.wvalid = 1; mi.bready = 1;
        tick();
        si.wready = 2'b10;
        #1;
        chk("split_awvalid", si.awvalid, 2'b10);
        chk("split_wvalid", si.wvalid, 2'b10);
        chk("split_wdata", si.wdata[63:32], 32'h0123_4567);
        chk("split_wstrb", si.wstrb[7:4], 4'h3);
        chk("split_m_ready", {mi.awready, mi.wready}, 2'b01);
        tick();
        mi.wvalid = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("split_w_dropped", si.wvalid, 2'b00);
            chk("split_aw_waiting", si.awvalid, 2'b10);
            tick();
        end
        si.awready = 2'b10;
        #1;
        chk("split_aw_hs", mi.awready, 1);
        tick();
        mi.awvalid = 0; si.awready = 0; si.wready = 0;
        si.bvalid = 2'b10; si.bresp = 4'b0000;
        #1;
        chk("split_bvalid", mi.bvalid, 1);
        chk("split_bresp", mi.bresp, 2'b00);
        chk("split_s_bready", si.bready, 2'b10);
        tick();
        si.bvalid = 0;
        #1;
        chk("split_b_done", mi.bvalid, 0);
        chk("split_w_once", w_hs1 - w0, 1);
        chk("split_aw_once", aw_hs1 - aw0, 1);

        // concurrent read slave0 + write slave1
        si.arready = 2'b01; si.awready = 2'b10; si.wready = 2'b10;
        mi.araddr = 32'h2000_0040; mi.arvalid = 1; mi.rready = 1;
        mi.awaddr = 32'h0200_0200; mi.wdata = 32'hFACE_0001; mi.wstrb = 4'hF;
        mi.awvalid = 1; mi.wvalid = 1; mi.bready = 1;
        tick();
        chk("conc_s_valids", {si.arvalid, si.awvalid, si.wvalid}, 6'b01_10_10);
        chk("conc_m_readies", {mi.arready, mi.awready, mi.wready}, 3'b111);
        tick();
        mi.arvalid = 0; mi.awvalid = 0; mi.wvalid = 0;
        si.arready = 0; si.awready = 0; si.wready = 0;
        si.rvalid = 2'b01; si.rdata = {32'h0, 32'h1234_5678}; si.rresp = 4'b0000;
        si.bvalid = 2'b10; si.bresp = 4'b0000;
        #1;
        chk("conc_rvalid", mi.rvalid, 1);
        chk("conc_rdata", mi.rdata, 32'h1234_5678);
        chk("conc_bvalid", mi.bvalid, 1);
        chk("conc_bresp", mi.bresp, 2'b00);
        tick();
        si.rvalid = 0; si.bvalid = 0;
        #1;
        chk("conc_done", {mi.rvalid, mi.bvalid}, 0);

        // asynchronous reset in the middle of a read
        mi.araddr = 32'h0200_0010; mi.arvalid = 1;
        tick();
        chk("mid_rst_pre", si.arvalid, 2'b10);
        rst = 0;
        #1;
        chk("mid_rst_arvalid", si.arvalid, 0);
        chk("mid_rst_arready", mi.arready, 0);
        mi.arvalid = 0;
        tick();
        rst = 1;
        tick();

`ifdef YSYX_25040129_XBAR_TIMEOUT_EN
        // watchdog: slave1 never answers
        mi.araddr = 32'h0200_0004; mi.arvalid = 1; mi.rready = 0;
        tick();
        si.arready = 2'b10;
        tick();
        mi.arvalid = 0; si.arready = 0;
        cyc = 0;
        while (!mi.rvalid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("to_cycles", cyc, 16);
        chk("to_rresp", mi.rresp, 2'b10);
        chk("to_rdata", mi.rdata, 0);
        mi.rready = 1;
        tick();
        cyc++;
        mi.rready = 0;
        mi.araddr = 32'h0200_0008; mi.arvalid = 1;
        #1;
        chk("to_drain_rready", si.rready, 2'b10);
        chk("to_drain_stall", mi.arready, 0);
        while (cyc < 40) begin
            tick();
            cyc++;
        end
        si.rvalid = 2'b10; si.rdata = {32'hDEAD_DEAD, 32'h0};
        tick();
        si.rvalid = 0;
        #1;
        chk("to_late_absorbed", mi.rvalid, 0);
        tick();
        si.arready = 2'b10;
        #1;
        chk("to_next_arready", mi.arready, 1);
        tick();
        mi.arvalid = 0; si.arready = 0; mi.rready = 1;
        si.rvalid = 2'b10; si.rdata = {32'h0BEE_F00D, 32'h0}; si.rresp = 4'b0000;
        #1;
        chk("to_next_rdata", mi.rdata, 32'h0BEE_F00D);
        chk("to_next_rresp", mi.rresp, 2'b00);
        tick();
        si.rvalid = 0;
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_25040129_axil_xbar.md
# ysyx_25040129_axil_xbar

Parametrised AXI4-Lite 1-to-N crossbar between the core's LSU/IFU arbiter and the SoC, RTC, CLINT and future slaves. Decodes each request against a per-slave base/mask map and forwards one transaction per channel at a time. Read and write channels run concurrently. Unmapped reads, unmapped writes and writes to read-only slaves get an internal error response, so the core never hangs.

## Interface
- NSLV, 4: number of slave ports (1..8)
- AW, 32: address width
- DW, 32: data width; wstrb is DW/8
- SLV_BASE, {NSLV{32'h0}}: flattened base addresses, slave i at [i*AW +: AW]
- SLV_MASK, {NSLV{32'h0}}: flattened masks; hit when (addr & mask) == base
- SLV_WR, {NSLV{1'b1}}: bit i = slave i accepts writes
- TIMEOUT_CYC, 1024: response watchdog limit (used only with the macro)
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- m_ar{addr,valid,size}/m_arready, m_r{data,resp,valid}/m_rready: master read channels (AW, 1, 3 / 1; DW, 2, 1 / 1)
- m_aw{addr,valid}/m_awready, m_w{data,strb,valid}/m_wready, m_b{resp,valid}/m_bready: master write channels
- s_* (same names, prefixed s_): slave buses flattened NSLV-wide. Each field is [i*W +: W]. Direction is mirrored.

## Operation
- Decode: lowest-index hit wins. No hit gives DECERR (2'b11). A write hit on a slave with SLV_WR[i]=0 gives SLVERR (2'b10).
- Read FSM has five states.
  - R_IDLE: on m_arvalid, register sel, addr and size. Go to R_REQ on a hit, else R_ERR.
  - R_REQ: drive s_arvalid[sel] with the registered addr/size. m_arready = s_arready[sel]. Go to R_DATA on handshake.
  - R_DATA: route s_r*[sel] to m_r*. s_rready[sel] = m_rready. Go to R_IDLE on m_rvalid&&m_rready.
  - R_ERR: m_arready=1 for one cycle, then R_ERESP.
  - R_ERESP: m_rvalid=1, m_rdata=0, error resp held until m_rready.
- Write FSM has five states.
  - W_IDLE: wait for m_awvalid&&m_wvalid, then register sel. Go to W_REQ on a writable hit, else W_ERR.
  - W_REQ: forward aw and w to sel independently, with sticky aw_done and w_done flags. A channel that is done drops its valid and its master ready. Go to W_RESP when both are done, including when both finish in the same cycle.
  - W_RESP: route b. Go to W_IDLE on the b handshake.
  - W_ERR: m_awready = m_wready = 1 for one cycle, then W_ERESP.
  - W_ERESP: m_bvalid with the error resp until m_bready.
- Idle signals:
  - All unselected slave valids/readies are 0.
  - Master outputs not driven by the current state are 0.
- The read and write FSMs are fully independent. A same-cycle read and write to the same slave both proceed; ordering between them is the slave's concern.

## Timing
- Reset (rst=0, asynchronous):
  - Both FSMs go to IDLE and sel=0.
  - All valid/ready outputs are 0. Data/resp outputs are 0.
  - Done flags and watchdog are cleared.
- Reset asserted mid-transaction aborts it silently. The slave side is not drained.
- Latency added: exactly one cycle (the IDLE decode register) before the slave sees valid. Response paths are combinational, with zero added latency.
- Error read: m_arready in cycle 1 after m_arvalid, m_rvalid from cycle 2.
- Master addr/data must stay stable while valid is high (AXI rule). The xbar forwards its registered address copy.

## Configuration
- YSYX_25040129_XBAR_TIMEOUT_EN defined:
  - A per-channel counter runs in R_DATA and W_RESP.
  - At TIMEOUT_CYC cycles without a response, the channel returns SLVERR to the master (R_ERESP / W_ERESP).
  - It then moves to a DRAIN state that holds s_rready / s_bready of sel at 1 until the late response arrives, then returns to IDLE. New master requests on that channel stall during DRAIN.
- Undefined: no counter and no DRAIN state; a silent slave hangs the channel.

## Structure
- Shared package/header: resp encodings OKAY/EXOKAY/SLVERR/DECERR, the read and write FSM state constants, and default map constants for ROM, SRAM, UART, FLASH, SPI, PSRAM, SDRAM, GPIO, PS2 and RTC.
- One sub-module, ysyx_25040129_xbar_decode: combinational addr → {hit, idx} using lowest-index priority. It is instantiated twice, once for ar and once for aw.

## Test plan
- NSLV=2, slave1 base 32'h0200_0000 mask 32'hFFFF_0000; read 32'h0200_0048 → s_arvalid[1] one cycle after m_arvalid, m_rdata equals slave data, resp 2'b00.
- Read 32'hDEAD_0000 (unmapped) → m_arready in cycle 1, m_rdata=0, resp 2'b11, no slave valid asserted.
- Write to slave with SLV_WR=0 → m_bresp=2'b10, slave sees no aw/w.
- Slave accepts w 3 cycles before aw → w forwarded exactly once, single b returned with resp 2'b00.
- Concurrent read of slave0 and write of slave1 in the same cycle → both complete, no stall of either.
- With macro and TIMEOUT_CYC=16, slave never asserts rvalid → m_rresp=2'b10 at cycle 16; late rvalid at cycle 40 is absorbed; next read succeeds.
